// File: rtl/wbu_pipe_pkg.sv
// rtl/wbu_pipe_pkg.sv - opcode and load funct3 constants shared by the write-back stage
package wbu_pipe_pkg;

  localparam logic [6:0] opcode_R       = 7'b0110011;
  localparam logic [6:0] opcode_I_lg    = 7'b0010011;
  localparam logic [6:0] opcode_I_ld    = 7'b0000011;
  localparam logic [6:0] opcode_U_lui   = 7'b0110111;
  localparam logic [6:0] opcode_U_auipc = 7'b0010111;
  localparam logic [6:0] opcode_J_jal   = 7'b1101111;
  localparam logic [6:0] opcode_J_jalr  = 7'b1100111;

  localparam logic [2:0] funct3_LB  = 3'b000;
  localparam logic [2:0] funct3_LH  = 3'b001;
  localparam logic [2:0] funct3_LW  = 3'b010;
  localparam logic [2:0] funct3_LD  = 3'b011;
  localparam logic [2:0] funct3_LBU = 3'b100;
  localparam logic [2:0] funct3_LHU = 3'b101;
  localparam logic [2:0] funct3_LWU = 3'b110;

  function automatic logic opcode_writes_rd(input logic [6:0] opcode);
    logic wen;
    case (opcode)
      opcode_R, opcode_I_lg, opcode_I_ld, opcode_U_lui,
      opcode_U_auipc, opcode_J_jal, opcode_J_jalr: wen = 1'b1;
      default: wen = 1'b0;
    endcase
    return wen;
  endfunction

endpackage

// File: rtl/wbu_load_fmt.sv
// rtl/wbu_load_fmt.sv - combinational load lane select, extension and alignment check
module wbu_load_fmt
  import wbu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data,
  output logic            err
);

  localparam bit IS64 = (XLEN == 64);

  logic [2:0]      byte_off;
  logic [XLEN-1:0] lane;

  // One byte shifter serves every size; aligned accesses land at bit 0.
  always_comb begin
    byte_off = IS64 ? addr : {1'b0, addr[1:0]};
    lane     = raw >> {byte_off, 3'b000};
    data     = '0;
    err      = 1'b0;
    case (funct3)
      funct3_LB:  data = XLEN'($signed(lane[7:0]));
      funct3_LBU: data = XLEN'(lane[7:0]);
      funct3_LH: begin
        data = XLEN'($signed(lane[15:0]));
        err  = addr[0];
      end
      funct3_LHU: begin
        data = XLEN'(lane[15:0]);
        err  = addr[0];
      end
      funct3_LW: begin
        data = XLEN'($signed(lane[31:0]));
        err  = |addr[1:0];
      end
      funct3_LWU: begin
        data = XLEN'(lane[31:0]);
        err  = !IS64 || (|addr[1:0]);
      end
      funct3_LD: begin
        data = lane;
        err  = !IS64 || (|addr);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wbu_pipe.sv
// rtl/wbu_pipe.sv - buffered write-back stage with hazard lookup
// Optional retire counter port enabled by WBU_RETIRE_CNT_EN.
module wbu_pipe
  import wbu_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [RF_AW-1:0] in_rd,
  input  logic [XLEN-1:0]  in_alu_out,
  input  logic [XLEN-1:0]  in_load_raw,
  input  logic             wb_hold,
  output logic             rf_wr_en,
  output logic [RF_AW-1:0] rf_rd,
  output logic [XLEN-1:0]  rf_data,
  output logic             wb_err,
  input  logic [RF_AW-1:0] q_rs,
  output logic             q_pending
`ifdef WBU_RETIRE_CNT_EN
  ,
  output logic [63:0]      retire_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic             ent_wen_q  [DEPTH];
  logic             ent_wen_d  [DEPTH];
  logic             ent_err_q  [DEPTH];
  logic             ent_err_d  [DEPTH];
  logic [RF_AW-1:0] ent_rd_q   [DEPTH];
  logic [RF_AW-1:0] ent_rd_d   [DEPTH];
  logic [XLEN-1:0]  ent_data_q [DEPTH];
  logic [XLEN-1:0]  ent_data_d [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot_off;
  logic [CW-1:0]    count_q, count_d;
  logic             rf_wr_en_q, rf_wr_en_d, wb_err_q, wb_err_d;
  logic [RF_AW-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_data_q, rf_data_d;

  logic             push, pop, is_load, fmt_err, push_err, push_wen;
  logic [XLEN-1:0]  fmt_data, push_data;

  wbu_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .funct3 (in_funct3),
    .addr   (in_alu_out[2:0]),
    .raw    (in_load_raw),
    .data   (fmt_data),
    .err    (fmt_err)
  );

  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && !wb_hold;

  // Entries are fully decoded at push so the pop side is a plain register load.
  always_comb begin
    is_load   = (in_opcode == opcode_I_ld);
    push_err  = is_load && fmt_err;
    push_wen  = opcode_writes_rd(in_opcode) && (in_rd != '0) && !push_err;
    push_data = is_load ? fmt_data : in_alu_out;
  end

  always_comb begin
    ent_wen_d  = ent_wen_q;
    ent_err_d  = ent_err_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rf_wr_en_d = 1'b0;
    wb_err_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_data_d  = rf_data_q;
    if (push) begin
      ent_wen_d[wr_ptr_q]  = push_wen;
      ent_err_d[wr_ptr_q]  = push_err;
      ent_rd_d[wr_ptr_q]   = in_rd;
      ent_data_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rf_wr_en_d = ent_wen_q[rd_ptr_q];
      wb_err_d   = ent_err_q[rd_ptr_q];
      rf_rd_d    = ent_rd_q[rd_ptr_q];
      rf_data_d  = ent_data_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_wr_en_q <= 1'b0;
      wb_err_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_wr_en_q <= rf_wr_en_d;
      wb_err_q   <= wb_err_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
    end
  end

  // Payload needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    ent_wen_q  <= ent_wen_d;
    ent_err_q  <= ent_err_d;
    ent_rd_q   <= ent_rd_d;
    ent_data_q <= ent_data_d;
  end

  always_comb begin
    slot_off  = '0;
    q_pending = rf_wr_en_q && (rf_rd_q == q_rs);
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if ((CW'(slot_off) < count_q) && ent_wen_q[i] && (ent_rd_q[i] == q_rs))
        q_pending = 1'b1;
    end
    if (q_rs == '0)
      q_pending = 1'b0;
  end

  assign rf_wr_en = rf_wr_en_q;
  assign wb_err   = wb_err_q;
  assign rf_rd    = rf_rd_q;
  assign rf_data  = rf_data_q;

`ifdef WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  always_comb retire_cnt_d = retire_cnt_q + 64'(pop);

  always_ff @(posedge clk) begin
    if (rst) retire_cnt_q <= '0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
